// File: rtl/armleocpu_axi_router_pkg.sv
// Shared AXI response encodings and router FSM state types.
package armleocpu_axi_router_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    WIdle,
    WData,
    WResp,
    WDecerrData,
    WDecerrResp
  } w_state_t;

  typedef enum logic [1:0] {
    RIdle,
    RData,
    RDecerr
  } r_state_t;

endpackage

// File: rtl/armleocpu_axi_address_decoder.sv
// Combinational priority region match: lowest matching client index wins.
module armleocpu_axi_address_decoder #(
  parameter int unsigned OPT_NUMBER_OF_CLIENTS = 2,
  parameter int unsigned ADDR_WIDTH = 34,
  parameter logic [OPT_NUMBER_OF_CLIENTS*ADDR_WIDTH-1:0] REGION_BASE_ADDR = '0,
  parameter logic [OPT_NUMBER_OF_CLIENTS*ADDR_WIDTH-1:0] REGION_END_ADDR = '0
) (
  input  logic [ADDR_WIDTH-1:0]            addr,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0] match,
  output logic                             unmapped
);

  always_comb begin
    match = '0;
    for (int i = 0; i < OPT_NUMBER_OF_CLIENTS; i++) begin
      if (match == '0 &&
          addr >= REGION_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          addr <  REGION_END_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        match[i] = 1'b1;
      end
    end
  end

  assign unmapped = (match == '0);

endmodule

// File: rtl/armleocpu_axi_router.sv
// AXI4 1-to-N router: address-decoded steering, one outstanding read and write,
// unmapped accesses completed locally with DECERR.
module armleocpu_axi_router
  import armleocpu_axi_router_pkg::*;
#(
  parameter int unsigned OPT_NUMBER_OF_CLIENTS = 2,
  parameter int unsigned ADDR_WIDTH = 34,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH = 4,
  parameter logic [OPT_NUMBER_OF_CLIENTS*ADDR_WIDTH-1:0] REGION_BASE_ADDR = '0,
  parameter logic [OPT_NUMBER_OF_CLIENTS*ADDR_WIDTH-1:0] REGION_END_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  upstream_axi_awvalid,
  output logic                  upstream_axi_awready,
  input  logic [ADDR_WIDTH-1:0] upstream_axi_awaddr,
  input  logic [7:0]            upstream_axi_awlen,
  input  logic [2:0]            upstream_axi_awsize,
  input  logic [1:0]            upstream_axi_awburst,
  input  logic [ID_WIDTH-1:0]   upstream_axi_awid,
  input  logic [2:0]            upstream_axi_awprot,
  input  logic                  upstream_axi_awlock,
  input  logic                  upstream_axi_wvalid,
  output logic                  upstream_axi_wready,
  input  logic [DATA_WIDTH-1:0] upstream_axi_wdata,
  input  logic [STRB_WIDTH-1:0] upstream_axi_wstrb,
  input  logic                  upstream_axi_wlast,
  output logic                  upstream_axi_bvalid,
  input  logic                  upstream_axi_bready,
  output logic [1:0]            upstream_axi_bresp,
  output logic [ID_WIDTH-1:0]   upstream_axi_bid,
  input  logic                  upstream_axi_arvalid,
  output logic                  upstream_axi_arready,
  input  logic [ADDR_WIDTH-1:0] upstream_axi_araddr,
  input  logic [7:0]            upstream_axi_arlen,
  input  logic [2:0]            upstream_axi_arsize,
  input  logic [1:0]            upstream_axi_arburst,
  input  logic [ID_WIDTH-1:0]   upstream_axi_arid,
  input  logic [2:0]            upstream_axi_arprot,
  input  logic                  upstream_axi_arlock,
  output logic                  upstream_axi_rvalid,
  input  logic                  upstream_axi_rready,
  output logic [DATA_WIDTH-1:0] upstream_axi_rdata,
  output logic [1:0]            upstream_axi_rresp,
  output logic [ID_WIDTH-1:0]   upstream_axi_rid,
  output logic                  upstream_axi_rlast,

  output logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_awvalid,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_awready,
  output logic [OPT_NUMBER_OF_CLIENTS*ADDR_WIDTH-1:0] client_axi_awaddr,
  output logic [OPT_NUMBER_OF_CLIENTS*8-1:0]          client_axi_awlen,
  output logic [OPT_NUMBER_OF_CLIENTS*3-1:0]          client_axi_awsize,
  output logic [OPT_NUMBER_OF_CLIENTS*2-1:0]          client_axi_awburst,
  output logic [OPT_NUMBER_OF_CLIENTS*ID_WIDTH-1:0]   client_axi_awid,
  output logic [OPT_NUMBER_OF_CLIENTS*3-1:0]          client_axi_awprot,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_awlock,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_wvalid,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_wready,
  output logic [OPT_NUMBER_OF_CLIENTS*DATA_WIDTH-1:0] client_axi_wdata,
  output logic [OPT_NUMBER_OF_CLIENTS*STRB_WIDTH-1:0] client_axi_wstrb,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_wlast,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_bvalid,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_bready,
  input  logic [OPT_NUMBER_OF_CLIENTS*2-1:0]          client_axi_bresp,
  input  logic [OPT_NUMBER_OF_CLIENTS*ID_WIDTH-1:0]   client_axi_bid,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_arvalid,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_arready,
  output logic [OPT_NUMBER_OF_CLIENTS*ADDR_WIDTH-1:0] client_axi_araddr,
  output logic [OPT_NUMBER_OF_CLIENTS*8-1:0]          client_axi_arlen,
  output logic [OPT_NUMBER_OF_CLIENTS*3-1:0]          client_axi_arsize,
  output logic [OPT_NUMBER_OF_CLIENTS*2-1:0]          client_axi_arburst,
  output logic [OPT_NUMBER_OF_CLIENTS*ID_WIDTH-1:0]   client_axi_arid,
  output logic [OPT_NUMBER_OF_CLIENTS*3-1:0]          client_axi_arprot,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_arlock,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_rvalid,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_rready,
  input  logic [OPT_NUMBER_OF_CLIENTS*DATA_WIDTH-1:0] client_axi_rdata,
  input  logic [OPT_NUMBER_OF_CLIENTS*2-1:0]          client_axi_rresp,
  input  logic [OPT_NUMBER_OF_CLIENTS*ID_WIDTH-1:0]   client_axi_rid,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]            client_axi_rlast
);

  localparam int unsigned N = OPT_NUMBER_OF_CLIENTS;
  localparam int unsigned SEL_WIDTH = (N > 1) ? $clog2(N) : 1;

  function automatic logic [SEL_WIDTH-1:0] onehot_to_sel(input logic [N-1:0] oh);
    onehot_to_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) onehot_to_sel = SEL_WIDTH'(i);
    end
  endfunction

  logic [N-1:0] aw_match, ar_match;
  logic         aw_unmapped, ar_unmapped;
  logic [SEL_WIDTH-1:0] aw_sel, ar_sel;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic [SEL_WIDTH-1:0] w_sel_q, w_sel_d, r_sel_q, r_sel_d;
  logic [ID_WIDTH-1:0]  w_id_q, w_id_d, r_id_q, r_id_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;

  armleocpu_axi_address_decoder #(
    .OPT_NUMBER_OF_CLIENTS(N),
    .ADDR_WIDTH(ADDR_WIDTH),
    .REGION_BASE_ADDR(REGION_BASE_ADDR),
    .REGION_END_ADDR(REGION_END_ADDR)
  ) u_aw_decoder (
    .addr(upstream_axi_awaddr),
    .match(aw_match),
    .unmapped(aw_unmapped)
  );

  armleocpu_axi_address_decoder #(
    .OPT_NUMBER_OF_CLIENTS(N),
    .ADDR_WIDTH(ADDR_WIDTH),
    .REGION_BASE_ADDR(REGION_BASE_ADDR),
    .REGION_END_ADDR(REGION_END_ADDR)
  ) u_ar_decoder (
    .addr(upstream_axi_araddr),
    .match(ar_match),
    .unmapped(ar_unmapped)
  );

  assign aw_sel = onehot_to_sel(aw_match);
  assign ar_sel = onehot_to_sel(ar_match);

  // Payloads are broadcast; only valid/ready are steered to the selected client.
  assign client_axi_awaddr  = {N{upstream_axi_awaddr}};
  assign client_axi_awlen   = {N{upstream_axi_awlen}};
  assign client_axi_awsize  = {N{upstream_axi_awsize}};
  assign client_axi_awburst = {N{upstream_axi_awburst}};
  assign client_axi_awid    = {N{upstream_axi_awid}};
  assign client_axi_awprot  = {N{upstream_axi_awprot}};
  assign client_axi_awlock  = {N{upstream_axi_awlock}};
  assign client_axi_wdata   = {N{upstream_axi_wdata}};
  assign client_axi_wstrb   = {N{upstream_axi_wstrb}};
  assign client_axi_wlast   = {N{upstream_axi_wlast}};
  assign client_axi_araddr  = {N{upstream_axi_araddr}};
  assign client_axi_arlen   = {N{upstream_axi_arlen}};
  assign client_axi_arsize  = {N{upstream_axi_arsize}};
  assign client_axi_arburst = {N{upstream_axi_arburst}};
  assign client_axi_arid    = {N{upstream_axi_arid}};
  assign client_axi_arprot  = {N{upstream_axi_arprot}};
  assign client_axi_arlock  = {N{upstream_axi_arlock}};

  always_comb begin
    w_state_d            = w_state_q;
    w_sel_d              = w_sel_q;
    w_id_d               = w_id_q;
    client_axi_awvalid   = '0;
    client_axi_wvalid    = '0;
    client_axi_bready    = '0;
    upstream_axi_awready = 1'b0;
    upstream_axi_wready  = 1'b0;
    upstream_axi_bvalid  = 1'b0;
    upstream_axi_bresp   = AXI_RESP_OKAY;
    upstream_axi_bid     = '0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_unmapped) begin
          upstream_axi_awready = upstream_axi_awvalid;
          if (upstream_axi_awvalid) begin
            w_id_d    = upstream_axi_awid;
            w_state_d = WDecerrData;
          end
        end else begin
          client_axi_awvalid   = aw_match & {N{upstream_axi_awvalid}};
          upstream_axi_awready = client_axi_awready[aw_sel];
          if (upstream_axi_awvalid && upstream_axi_awready) begin
            w_sel_d   = aw_sel;
            w_state_d = WData;
          end
        end
      end
      WData: begin
        client_axi_wvalid[w_sel_q] = upstream_axi_wvalid;
        upstream_axi_wready        = client_axi_wready[w_sel_q];
        if (upstream_axi_wvalid && upstream_axi_wready && upstream_axi_wlast) w_state_d = WResp;
      end
      WResp: begin
        upstream_axi_bvalid        = client_axi_bvalid[w_sel_q];
        upstream_axi_bresp         = client_axi_bresp[w_sel_q*2 +: 2];
        upstream_axi_bid           = client_axi_bid[w_sel_q*ID_WIDTH +: ID_WIDTH];
        client_axi_bready[w_sel_q] = upstream_axi_bready;
        if (upstream_axi_bvalid && upstream_axi_bready) w_state_d = WIdle;
      end
      WDecerrData: begin
        upstream_axi_wready = 1'b1;
        if (upstream_axi_wvalid && upstream_axi_wlast) w_state_d = WDecerrResp;
      end
      WDecerrResp: begin
        upstream_axi_bvalid = 1'b1;
        upstream_axi_bresp  = AXI_RESP_DECERR;
        upstream_axi_bid    = w_id_q;
        if (upstream_axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
    if (rst) begin
      client_axi_awvalid = '0;
      client_axi_wvalid  = '0;
    end
  end

  always_comb begin
    r_state_d            = r_state_q;
    r_sel_d              = r_sel_q;
    r_id_d               = r_id_q;
    beat_cnt_d           = beat_cnt_q;
    client_axi_arvalid   = '0;
    client_axi_rready    = '0;
    upstream_axi_arready = 1'b0;
    upstream_axi_rvalid  = 1'b0;
    upstream_axi_rdata   = '0;
    upstream_axi_rresp   = AXI_RESP_OKAY;
    upstream_axi_rid     = '0;
    upstream_axi_rlast   = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        if (ar_unmapped) begin
          upstream_axi_arready = upstream_axi_arvalid;
          if (upstream_axi_arvalid) begin
            r_id_d     = upstream_axi_arid;
            beat_cnt_d = upstream_axi_arlen;
            r_state_d  = RDecerr;
          end
        end else begin
          client_axi_arvalid   = ar_match & {N{upstream_axi_arvalid}};
          upstream_axi_arready = client_axi_arready[ar_sel];
          if (upstream_axi_arvalid && upstream_axi_arready) begin
            r_sel_d   = ar_sel;
            r_state_d = RData;
          end
        end
      end
      RData: begin
        upstream_axi_rvalid        = client_axi_rvalid[r_sel_q];
        upstream_axi_rdata         = client_axi_rdata[r_sel_q*DATA_WIDTH +: DATA_WIDTH];
        upstream_axi_rresp         = client_axi_rresp[r_sel_q*2 +: 2];
        upstream_axi_rid           = client_axi_rid[r_sel_q*ID_WIDTH +: ID_WIDTH];
        upstream_axi_rlast         = client_axi_rlast[r_sel_q];
        client_axi_rready[r_sel_q] = upstream_axi_rready;
        if (upstream_axi_rvalid && upstream_axi_rready && upstream_axi_rlast) r_state_d = RIdle;
      end
      RDecerr: begin
        upstream_axi_rvalid = 1'b1;
        upstream_axi_rresp  = AXI_RESP_DECERR;
        upstream_axi_rid    = r_id_q;
        upstream_axi_rlast  = (beat_cnt_q == 8'd0);
        if (upstream_axi_rready) begin
          // Hold at zero on the last beat so the counter never wraps.
          if (upstream_axi_rlast) r_state_d = RIdle;
          else beat_cnt_d = beat_cnt_q - 8'd1;
        end
      end
      default: r_state_d = RIdle;
    endcase
    if (rst) client_axi_arvalid = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= WIdle;
      r_state_q  <= RIdle;
      w_sel_q    <= '0;
      r_sel_q    <= '0;
      w_id_q     <= '0;
      r_id_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      w_sel_q    <= w_sel_d;
      r_sel_q    <= r_sel_d;
      w_id_q     <= w_id_d;
      r_id_q     <= r_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_armleocpu_axi_router.sv
// Directed bench for the AXI router: three clients with an overlapping third region.
module tb_armleocpu_axi_router;
  localparam int N = 3, AW = 34, DW = 32, SW = 4, IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          up_awvalid, up_awready, up_awlock;
  logic [AW-1:0] up_awaddr;
  logic [7:0]    up_awlen;
  logic [2:0]    up_awsize, up_awprot;
  logic [1:0]    up_awburst;
  logic [IW-1:0] up_awid;
  logic          up_wvalid, up_wready, up_wlast;
  logic [DW-1:0] up_wdata;
  logic [SW-1:0] up_wstrb;
  logic          up_bvalid, up_bready;
  logic [1:0]    up_bresp;
  logic [IW-1:0] up_bid;
  logic          up_arvalid, up_arready, up_arlock;
  logic [AW-1:0] up_araddr;
  logic [7:0]    up_arlen;
  logic [2:0]    up_arsize, up_arprot;
  logic [1:0]    up_arburst;
  logic [IW-1:0] up_arid;
  logic          up_rvalid, up_rready, up_rlast;
  logic [DW-1:0] up_rdata;
  logic [1:0]    up_rresp;
  logic [IW-1:0] up_rid;

  logic [N-1:0]    c_awvalid, c_awready, c_awlock, c_wvalid, c_wready, c_wlast;
  logic [N-1:0]    c_bvalid, c_bready, c_arvalid, c_arready, c_arlock;
  logic [N-1:0]    c_rvalid, c_rready, c_rlast;
  logic [N*AW-1:0] c_awaddr, c_araddr;
  logic [N*8-1:0]  c_awlen, c_arlen;
  logic [N*3-1:0]  c_awsize, c_awprot, c_arsize, c_arprot;
  logic [N*2-1:0]  c_awburst, c_arburst, c_bresp, c_rresp;
  logic [N*IW-1:0] c_awid, c_arid, c_bid, c_rid;
  logic [N*DW-1:0] c_wdata, c_rdata;
  logic [N*SW-1:0] c_wstrb;

  armleocpu_axi_router #(
    .OPT_NUMBER_OF_CLIENTS(N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ID_WIDTH(IW),
    .REGION_BASE_ADDR({34'h1800, 34'h1000, 34'h0000}),
    .REGION_END_ADDR({34'h3000, 34'h2000, 34'h1000})
  ) dut (
    .clk(clk), .rst(rst),
    .upstream_axi_awvalid(up_awvalid), .upstream_axi_awready(up_awready),
    .upstream_axi_awaddr(up_awaddr), .upstream_axi_awlen(up_awlen),
    .upstream_axi_awsize(up_awsize), .upstream_axi_awburst(up_awburst),
    .upstream_axi_awid(up_awid), .upstream_axi_awprot(up_awprot),
    .upstream_axi_awlock(up_awlock),
    .upstream_axi_wvalid(up_wvalid), .upstream_axi_wready(up_wready),
    .upstream_axi_wdata(up_wdata), .upstream_axi_wstrb(up_wstrb),
    .upstream_axi_wlast(up_wlast),
    .upstream_axi_bvalid(up_bvalid), .upstream_axi_bready(up_bready),
    .upstream_axi_bresp(up_bresp), .upstream_axi_bid(up_bid),
    .upstream_axi_arvalid(up_arvalid), .upstream_axi_arready(up_arready),
    .upstream_axi_araddr(up_araddr), .upstream_axi_arlen(up_arlen),
    .upstream_axi_arsize(up_arsize), .upstream_axi_arburst(up_arburst),
    .upstream_axi_arid(up_arid), .upstream_axi_arprot(up_arprot),
    .upstream_axi_arlock(up_arlock),
    .upstream_axi_rvalid(up_rvalid), .upstream_axi_rready(up_rready),
    .upstream_axi_rdata(up_rdata), .upstream_axi_rresp(up_rresp),
    .upstream_axi_rid(up_rid), .upstream_axi_rlast(up_rlast),
    .client_axi_awvalid(c_awvalid), .client_axi_awready(c_awready),
    .client_axi_awaddr(c_awaddr), .client_axi_awlen(c_awlen),
    .client_axi_awsize(c_awsize), .client_axi_awburst(c_awburst),
    .client_axi_awid(c_awid), .client_axi_awprot(c_awprot),
    .client_axi_awlock(c_awlock),
    .client_axi_wvalid(c_wvalid), .client_axi_wready(c_wready),
    .client_axi_wdata(c_wdata), .client_axi_wstrb(c_wstrb),
    .client_axi_wlast(c_wlast),
    .client_axi_bvalid(c_bvalid), .client_axi_bready(c_bready),
    .client_axi_bresp(c_bresp), .client_axi_bid(c_bid),
    .client_axi_arvalid(c_arvalid), .client_axi_arready(c_arready),
    .client_axi_araddr(c_araddr), .client_axi_arlen(c_arlen),
    .client_axi_arsize(c_arsize), .client_axi_arburst(c_arburst),
    .client_axi_arid(c_arid), .client_axi_arprot(c_arprot),
    .client_axi_arlock(c_arlock),
    .client_axi_rvalid(c_rvalid), .client_axi_rready(c_rready),
    .client_axi_rdata(c_rdata), .client_axi_rresp(c_rresp),
    .client_axi_rid(c_rid), .client_axi_rlast(c_rlast)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats;
    bit done;
    rst = 1'b1;
    up_awvalid = 0; up_awaddr = '0; up_awlen = '0; up_awsize = 3'd2; up_awburst = 2'b01;
    up_awid = '0; up_awprot = '0; up_awlock = 0;
    up_wvalid = 0; up_wdata = '0; up_wstrb = 4'hF; up_wlast = 0; up_bready = 0;
    up_arvalid = 0; up_araddr = '0; up_arlen = '0; up_arsize = 3'd2; up_arburst = 2'b01;
    up_arid = '0; up_arprot = '0; up_arlock = 0; up_rready = 0;
    c_awready = '0; c_wready = '0; c_bvalid = '0; c_bresp = '0; c_bid = '0;
    c_arready = '0; c_rvalid = '0; c_rdata = '0; c_rresp = '0; c_rid = '0; c_rlast = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset_awready", up_awready, 0);
    check("reset_arready", up_arready, 0);
    check("reset_wready", up_wready, 0);
    check("reset_bvalid", up_bvalid, 0);
    check("reset_rvalid", up_rvalid, 0);
    check("reset_client_valids", {c_awvalid, c_wvalid, c_arvalid}, 0);

    // W offered before AW must be held off
    up_wvalid = 1; up_wdata = 32'h1234;
    #1;
    check("w_before_aw_wready", up_wready, 0);
    check("w_before_aw_client", c_wvalid, 0);
    up_wvalid = 0;

    // Mapped write len=3 to client 1, with one cycle of W backpressure
    c_awready = '1; c_wready = '1;
    up_awvalid = 1; up_awaddr = 34'h1004; up_awlen = 8'd3; up_awid = 4'd5; up_awsize = 3'd2;
    #1;
    check("wr_aw_route", c_awvalid, 3'b010);
    check("wr_awready", up_awready, 1);
    check("wr_awaddr_c1", c_awaddr[1*AW +: AW], 34'h1004);
    check("wr_awsize_c1", c_awsize[1*3 +: 3], 3'd2);
    tick();
    up_awvalid = 0;
    for (int b = 0; b < 4; b++) begin
      up_wvalid = 1; up_wdata = 32'hA0 + b; up_wlast = (b == 3);
      if (b == 2) begin
        c_wready = '0;
        #1;
        check("wr_bp_wready", up_wready, 0);
        check("wr_bp_wdata", c_wdata[1*DW +: DW], 32'hA2);
        tick();
        c_wready = '1;
      end
      #1;
      check("wr_w_route", c_wvalid, 3'b010);
      check("wr_wdata", c_wdata[1*DW +: DW], 32'hA0 + b);
      check("wr_wlast", c_wlast[1], (b == 3));
      tick();
    end
    up_wvalid = 0; up_wlast = 0;
    #1;
    check("wr_no_b_yet", up_bvalid, 0);
    c_bvalid = 3'b010; c_bresp = 6'b00_00_00; c_bid = {4'h0, 4'h5, 4'h0}; up_bready = 1;
    #1;
    check("wr_bvalid", up_bvalid, 1);
    check("wr_bid", up_bid, 5);
    check("wr_bresp", up_bresp, 0);
    check("wr_bready_route", c_bready, 3'b010);
    tick();
    c_bvalid = '0; up_bready = 0;
    #1;
    check("wr_idle_bvalid", up_bvalid, 0);

    // Unmapped read len=0 at the exclusive end of the last region
    c_arready = '1;
    up_arvalid = 1; up_araddr = 34'h3000; up_arlen = 8'd0; up_arid = 4'hA;
    #1;
    check("rd_dec_arready", up_arready, 1);
    check("rd_dec_no_client", c_arvalid, 0);
    tick();
    up_arvalid = 0;
    #1;
    check("rd_dec_rvalid", up_rvalid, 1);
    check("rd_dec_rresp", up_rresp, 2'b11);
    check("rd_dec_rdata", up_rdata, 0);
    check("rd_dec_rlast", up_rlast, 1);
    check("rd_dec_rid", up_rid, 4'hA);
    up_rready = 1;
    tick();
    up_rready = 0;
    #1;
    check("rd_dec_done", up_rvalid, 0);

    // Unmapped write len=7
    up_awvalid = 1; up_awaddr = 34'h5000; up_awlen = 8'd7; up_awid = 4'd3;
    #1;
    check("wr_dec_awready", up_awready, 1);
    check("wr_dec_no_client", c_awvalid, 0);
    tick();
    up_awvalid = 0;
    for (int b = 0; b < 8; b++) begin
      up_wvalid = 1; up_wdata = 32'hD0 + b; up_wlast = (b == 7);
      #1;
      check("wr_dec_wready", up_wready, 1);
      check("wr_dec_w_client", c_wvalid, 0);
      check("wr_dec_b_early", up_bvalid, 0);
      tick();
    end
    up_wvalid = 0; up_wlast = 0;
    #1;
    check("wr_dec_bvalid", up_bvalid, 1);
    check("wr_dec_bresp", up_bresp, 2'b11);
    check("wr_dec_bid", up_bid, 4'd3);
    up_bready = 1;
    tick();
    up_bready = 0;

    // Unmapped read arlen=255: exactly 256 beats, rlast only on the final one
    up_arvalid = 1; up_araddr = 34'h8000; up_arlen = 8'd255; up_arid = 4'd7;
    #1;
    check("rd256_arready", up_arready, 1);
    tick();
    up_arvalid = 0; up_rready = 1;
    #1;
    check("rd256_rid", up_rid, 4'd7);
    beats = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (up_rvalid) begin
        beats++;
        if (up_rlast) done = 1;
      end
      tick();
    end
    check("rd256_finished", done, 1);
    check("rd256_beats", beats, 256);
    up_rready = 0;
    #1;
    check("rd256_idle", up_rvalid, 0);

    // Concurrent read from client 0 and write to client 2, both backpressured first
    c_awready = '1; c_arready = '1;
    up_arvalid = 1; up_araddr = 34'h100; up_arlen = 8'd0; up_arid = 4'd1;
    up_awvalid = 1; up_awaddr = 34'h2800; up_awlen = 8'd0; up_awid = 4'd2;
    #1;
    check("cc_ar_route", c_arvalid, 3'b001);
    check("cc_aw_route", c_awvalid, 3'b100);
    check("cc_readies", {up_arready, up_awready}, 2'b11);
    tick();
    up_arvalid = 0; up_awvalid = 0;
    c_rvalid = 3'b001; c_rdata = {32'h0, 32'h0, 32'hCAFE}; c_rlast = 3'b001;
    c_rid = {4'h0, 4'h0, 4'h1}; c_rresp = '0;
    up_wvalid = 1; up_wdata = 32'hBEEF; up_wlast = 1; c_wready = 3'b000;
    #1;
    check("cc_rvalid", up_rvalid, 1);
    check("cc_rdata", up_rdata, 32'hCAFE);
    check("cc_rid", up_rid, 4'd1);
    check("cc_rready_held", c_rready, 0);
    check("cc_wready_held", up_wready, 0);
    check("cc_w_route", c_wvalid, 3'b100);
    check("cc_wdata_c2", c_wdata[2*DW +: DW], 32'hBEEF);
    check("cc_no_cross", {c_arvalid, c_awvalid}, 0);
    tick();
    check("cc_rdata_stable", up_rdata, 32'hCAFE);
    up_rready = 1; c_wready = 3'b100;
    #1;
    check("cc_rready_route", c_rready, 3'b001);
    check("cc_wready", up_wready, 1);
    tick();
    c_rvalid = '0; c_rlast = '0; up_rready = 0; up_wvalid = 0; up_wlast = 0;
    c_bvalid = 3'b100; c_bid = {4'h2, 4'h0, 4'h0}; c_bresp = {2'b01, 2'b00, 2'b00};
    up_bready = 1;
    #1;
    check("cc_rd_done", up_rvalid, 0);
    check("cc_bvalid", up_bvalid, 1);
    check("cc_bid", up_bid, 4'd2);
    check("cc_bresp", up_bresp, 2'b01);
    tick();
    c_bvalid = '0; up_bready = 0;

    // Overlap priority: lowest matching index wins
    c_awready = '0;
    up_awvalid = 1; up_awaddr = 34'h1800;
    #1;
    check("prio_1800", c_awvalid, 3'b010);
    check("prio_no_accept", up_awready, 0);
    up_awaddr = 34'h2FFF;
    #1;
    check("prio_2fff", c_awvalid, 3'b100);
    up_awaddr = 34'h0FFF;
    #1;
    check("prio_0fff", c_awvalid, 3'b001);
    up_awvalid = 0;

    // Reset in the middle of a 4-beat write, then a clean write
    c_awready = '1; c_wready = '1;
    up_awvalid = 1; up_awaddr = 34'h40; up_awlen = 8'd3; up_awid = 4'd4;
    tick();
    up_awvalid = 0; up_wvalid = 1; up_wdata = 32'h1; up_wlast = 0;
    tick();
    up_wdata = 32'h2; rst = 1;
    #1;
    check("rst_client_wvalid", c_wvalid, 0);
    tick();
    rst = 0;
    #1;
    check("rst_idle_wready", up_wready, 0);
    check("rst_idle_client_w", c_wvalid, 0);
    up_wvalid = 0;
    up_awvalid = 1; up_awaddr = 34'h80; up_awlen = 8'd0; up_awid = 4'd6;
    #1;
    check("post_rst_aw", c_awvalid, 3'b001);
    tick();
    up_awvalid = 0; up_wvalid = 1; up_wdata = 32'h77; up_wlast = 1;
    #1;
    check("post_rst_w", {c_wvalid, up_wready}, 4'b0011);
    tick();
    up_wvalid = 0; up_wlast = 0;
    c_bvalid = 3'b001; c_bid = {4'h0, 4'h0, 4'h6}; c_bresp = '0; up_bready = 1;
    #1;
    check("post_rst_bvalid", up_bvalid, 1);
    check("post_rst_bid", up_bid, 4'd6);
    tick();
    c_bvalid = '0; up_bready = 0;
    #1;
    check("post_rst_idle", up_bvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
